conv2d: RTL and testbench
=========================

CONV2D -- requirements
Module: conv2d

Interface
REQ-001 SHALL have parameter BATCH_SIZE, default 1: images per tensor.
REQ-002 SHALL have parameter IN_CHANNELS, default 2: input channels.
REQ-003 SHALL have parameter OUT_CHANNELS, default 1: output channels (filters).
REQ-004 SHALL have parameters IN_HEIGHT and IN_WIDTH, each default 4: input spatial size.
REQ-005 SHALL have parameters KERNEL_SIZE (default 2), STRIDE (default 2) and PADDING (default 0): square kernel, step and zero border.
REQ-006 SHALL have parameter DATA_WIDTH, default 32: element width.
REQ-007 SHALL derive OUT_H = (IN_HEIGHT+2*PADDING-KERNEL_SIZE)/STRIDE+1, OUT_W likewise with IN_WIDTH, and OUT_SIZE = BATCH_SIZE*OUT_CHANNELS*OUT_H*OUT_W.
REQ-008 SHALL have clk, input, 1 bit: the single clock, rising-edge active.
REQ-009 SHALL have rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have input_tensor_flat, input, BATCH_SIZE*IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH bits: element ((b*IC+c)*IN_HEIGHT+y)*IN_WIDTH+x at bits [idx*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have weights_flat, input, OUT_CHANNELS*IN_CHANNELS*KERNEL_SIZE^2*DATA_WIDTH bits: element ((oc*IC+ic)*K+ky)*K+kx.
REQ-012 SHALL have bias_flat, input, OUT_CHANNELS*DATA_WIDTH bits: element oc.
REQ-013 SHALL have output_tensor_flat, output, OUT_SIZE*DATA_WIDTH bits, registered: element ((b*OC+oc)*OUT_H+oy)*OUT_W+ox.
REQ-014 SHALL have done, output, 1 bit, registered: computation complete.

Function
REQ-015 SHALL compute out[b,oc,oy,ox] = bias[oc] + sum over ic,ky,kx of in[b,ic,oy*STRIDE+ky-PADDING,ox*STRIDE+kx-PADDING]*w[oc,ic,ky,kx]; out-of-range taps contribute 0.
REQ-016 SHALL treat all values as signed two's complement; products and accumulator truncated to DATA_WIDTH (modulo wrap, no saturation).
REQ-017 SHALL start automatically on the first rising clk edge after rst_n deasserts; no start input.
REQ-018 SHALL read inputs combinationally during computation; inputs SHALL be held stable until done.
REQ-019 SHALL use one multiplier, performing exactly one multiply-accumulate per cycle.
REQ-020 SHALL use states INIT (acc <= bias[oc]), MAC (IC*K*K cycles, kx fastest, then ky, then ic), WRITE (store acc into the output slot, advance ox, oy, oc, b in that order), DONE.
REQ-021 SHALL transition INIT->MAC after 1 cycle, MAC->WRITE after the last tap, WRITE->INIT for further outputs, WRITE->DONE after the last output.
REQ-022 SHALL make each output take IC*K*K+2 cycles; done rises on edge OUT_SIZE*(IC*K*K+2) after reset release (40 with defaults).
REQ-023 SHALL hold done=1 and all outputs stable in DONE until reset; no recomputation when inputs change.
REQ-024 SHALL leave not-yet-written output elements at 0 during computation.

Reset
REQ-025 SHALL, while rst_n=0, clear output_tensor_flat to 0, done to 0, accumulator and all counters to 0, and enter INIT.
REQ-026 SHALL abort any computation on reset mid-operation and restart from output 0 after release.

Configuration
REQ-027 SHALL, with macro CONV2D_RELU_EN defined, store max(acc,0) in WRITE (negative results become 0).
REQ-028 SHALL, without CONV2D_RELU_EN, store acc unmodified.

Verification
REQ-029 Defaults, input element i = i (0..31), weights all 1, bias 0 -> outputs 84, 100, 148, 164; done on edge 40.
REQ-030 Same input, bias 5 -> outputs 89, 105, 153, 169.
REQ-031 Same input, weights all -1 -> -84, -100, -148, -164 without CONV2D_RELU_EN; all 0 with it.
REQ-032 rst_n pulsed low at cycle 15 -> outputs and done immediately 0; after release, correct results with done again 40 edges later.
REQ-033 IC=1, 4x4 input all 1, K=3, STRIDE=1, PADDING=1, weights 1, bias 0 -> corners 4, edges 6, interior 9; done after 16*11=176 edges.
REQ-034 Inputs changed after done -> outputs and done unchanged.

Source files
------------

// File: rtl/conv2d.sv
// conv2d: direct 2-D convolution over a flat input tensor, one multiply-accumulate per cycle.
// Latency: IC*K*K+2 cycles per output element; done after OUT_SIZE of them, then holds until reset.
// No backpressure: inputs are sampled live and must stay stable until done. Optional ReLU: CONV2D_RELU_EN.
module conv2d #(
  parameter int BATCH_SIZE   = 1,
  parameter int IN_CHANNELS  = 2,
  parameter int OUT_CHANNELS = 1,
  parameter int IN_HEIGHT    = 4,
  parameter int IN_WIDTH     = 4,
  parameter int KERNEL_SIZE  = 2,
  parameter int STRIDE       = 2,
  parameter int PADDING      = 0,
  parameter int DATA_WIDTH   = 32,
  localparam int OUT_H    = (IN_HEIGHT + 2*PADDING - KERNEL_SIZE) / STRIDE + 1,
  localparam int OUT_W    = (IN_WIDTH  + 2*PADDING - KERNEL_SIZE) / STRIDE + 1,
  localparam int OUT_SIZE = BATCH_SIZE * OUT_CHANNELS * OUT_H * OUT_W
) (
  input  logic                                                          clk,
  input  logic                                                          rst_n,
  input  logic [BATCH_SIZE*IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0] input_tensor_flat,
  input  logic [OUT_CHANNELS*IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights_flat,
  input  logic [OUT_CHANNELS*DATA_WIDTH-1:0]                            bias_flat,
  output logic [OUT_SIZE*DATA_WIDTH-1:0]                                output_tensor_flat,
  output logic                                                          done
);

  typedef enum logic [1:0] {INIT, MAC, WRITE, DONE} state_t;

  state_t                         state_q, state_d;
  logic [31:0]                    kx_q, kx_d, ky_q, ky_d, ic_q, ic_d;
  logic [31:0]                    ox_q, ox_d, oy_q, oy_d, oc_q, oc_d, b_q, b_d;
  logic [DATA_WIDTH-1:0]          acc_q, acc_d;
  logic [OUT_SIZE*DATA_WIDTH-1:0] out_q, out_d;
  logic                           done_q, done_d;

  int                    iy, ix, in_idx, w_idx, out_idx;
  logic                  tap_vld;
  logic [DATA_WIDTH-1:0] in_val, w_val, prod, res;

  // Current tap: locate the input pixel (zero when it falls in the padding border) and its weight.
  always_comb begin
    iy      = int'(oy_q) * STRIDE + int'(ky_q) - PADDING;
    ix      = int'(ox_q) * STRIDE + int'(kx_q) - PADDING;
    tap_vld = (iy >= 0) && (iy < IN_HEIGHT) && (ix >= 0) && (ix < IN_WIDTH);
    in_idx  = tap_vld ? ((int'(b_q) * IN_CHANNELS + int'(ic_q)) * IN_HEIGHT + iy) * IN_WIDTH + ix : 0;
    w_idx   = ((int'(oc_q) * IN_CHANNELS + int'(ic_q)) * KERNEL_SIZE + int'(ky_q)) * KERNEL_SIZE
              + int'(kx_q);
    out_idx = ((int'(b_q) * OUT_CHANNELS + int'(oc_q)) * OUT_H + int'(oy_q)) * OUT_W + int'(ox_q);
    in_val  = tap_vld ? input_tensor_flat[in_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    w_val   = weights_flat[w_idx*DATA_WIDTH +: DATA_WIDTH];
    // Low DATA_WIDTH bits of a two's-complement product do not depend on signedness.
    prod    = in_val * w_val;
`ifdef CONV2D_RELU_EN
    res     = acc_q[DATA_WIDTH-1] ? '0 : acc_q;
`else
    res     = acc_q;
`endif
  end

  // Sequencer: bias load, tap walk (kx fastest), output store and output-index advance.
  always_comb begin
    state_d = state_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    ic_d    = ic_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    oc_d    = oc_q;
    b_d     = b_q;
    acc_d   = acc_q;
    out_d   = out_q;
    done_d  = done_q;
    case (state_q)
      INIT: begin
        acc_d   = bias_flat[int'(oc_q)*DATA_WIDTH +: DATA_WIDTH];
        state_d = MAC;
      end
      MAC: begin
        acc_d = acc_q + prod;
        if (kx_q == 32'(KERNEL_SIZE - 1)) begin
          kx_d = '0;
          if (ky_q == 32'(KERNEL_SIZE - 1)) begin
            ky_d = '0;
            if (ic_q == 32'(IN_CHANNELS - 1)) begin
              ic_d    = '0;
              state_d = WRITE;
            end else begin
              ic_d = ic_q + 32'd1;
            end
          end else begin
            ky_d = ky_q + 32'd1;
          end
        end else begin
          kx_d = kx_q + 32'd1;
        end
      end
      WRITE: begin
        out_d[out_idx*DATA_WIDTH +: DATA_WIDTH] = res;
        state_d = INIT;
        if (ox_q == 32'(OUT_W - 1)) begin
          ox_d = '0;
          if (oy_q == 32'(OUT_H - 1)) begin
            oy_d = '0;
            if (oc_q == 32'(OUT_CHANNELS - 1)) begin
              oc_d = '0;
              if (b_q == 32'(BATCH_SIZE - 1)) begin
                b_d     = '0;
                state_d = DONE;
                done_d  = 1'b1;
              end else begin
                b_d = b_q + 32'd1;
              end
            end else begin
              oc_d = oc_q + 32'd1;
            end
          end else begin
            oy_d = oy_q + 32'd1;
          end
        end else begin
          ox_d = ox_q + 32'd1;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = INIT;
    endcase
  end

  // State register; reset clears every result and counter so a restart begins at output 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      kx_q    <= '0;
      ky_q    <= '0;
      ic_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      oc_q    <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      ic_q    <= ic_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      oc_q    <= oc_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign output_tensor_flat = out_q;
  assign done               = done_q;

endmodule

// File: tb/tb_conv2d.sv
// Self-checking bench for conv2d: default geometry plus a padded 3x3 stride-1 instance.
// Expected outputs come from a direct-formula reference model pushed into a scoreboard queue.
// Done timing is checked by counting rising edges after reset release.
module tb_conv2d;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [32*DW-1:0] in_a  = '0;
  logic [8*DW-1:0]  w_a   = '0;
  logic [DW-1:0]    b_a   = '0;
  logic [4*DW-1:0]  out_a;
  logic             done_a;

  logic [16*DW-1:0] in_b  = '0;
  logic [9*DW-1:0]  w_b   = '0;
  logic [DW-1:0]    b_b   = '0;
  logic [16*DW-1:0] out_b;
  logic             done_b;

  conv2d dut_a (
    .clk(clk), .rst_n(rst_n), .input_tensor_flat(in_a), .weights_flat(w_a),
    .bias_flat(b_a), .output_tensor_flat(out_a), .done(done_a)
  );

  conv2d #(.IN_CHANNELS(1), .KERNEL_SIZE(3), .STRIDE(1), .PADDING(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .input_tensor_flat(in_b), .weights_flat(w_b),
    .bias_flat(b_b), .output_tensor_flat(out_b), .done(done_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int m_in[64];
  int m_w[16];

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: batch 0, filter 0, straight from the convolution formula.
  function automatic int ref_px(int ic_n, int ih, int iw, int k, int s, int p,
                                int oy, int ox, int bias);
    int acc = bias;
    for (int c = 0; c < ic_n; c++)
      for (int ky = 0; ky < k; ky++)
        for (int kx = 0; kx < k; kx++) begin
          int y = oy * s + ky - p;
          int x = ox * s + kx - p;
          if (y >= 0 && y < ih && x >= 0 && x < iw)
            acc += m_in[(c * ih + y) * iw + x] * m_w[(c * k + ky) * k + kx];
        end
`ifdef CONV2D_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return acc;
  endfunction

  task automatic load_a(input int bias);
    for (int i = 0; i < 32; i++) in_a[i*DW +: DW] = m_in[i];
    for (int i = 0; i < 8; i++)  w_a[i*DW +: DW]  = m_w[i];
    b_a = bias;
    for (int oy = 0; oy < 2; oy++)
      for (int ox = 0; ox < 2; ox++)
        exp_q.push_back(ref_px(2, 4, 4, 2, 2, 0, oy, ox, bias));
  endtask

  task automatic reset_start(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk({tag, "_rst_done"}, int'(done_a), 0);
    chk({tag, "_rst_out0"}, int'(out_a[0 +: DW]), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_outs_a(input string tag);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_out%0d", tag, i), int'(out_a[i*DW +: DW]), exp_q.pop_front());
  endtask

  task automatic run_a(input string tag, input int bias);
    int n, s0, s1;
    load_a(bias);
    reset_start(tag);
    n = 0; s0 = -1; s1 = -1;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (n == 10) begin
        s0 = int'(out_a[0 +: DW]);
        s1 = int'(out_a[DW +: DW]);
      end
      if (done_a) break;
    end
    chk({tag, "_done_edge"}, n, 40);
    chk({tag, "_mid_out0"}, s0, exp_q[0]);
    chk({tag, "_mid_out1"}, s1, 0);
    check_outs_a(tag);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) m_in[i] = i;
    for (int i = 0; i < 16; i++) m_w[i] = 1;

    run_a("base", 0);
    run_a("bias5", 5);
    for (int i = 0; i < 16; i++) m_w[i] = -1;
    run_a("neg", 0);

    // Reset asserted mid-computation, after the first output has been stored.
    for (int i = 0; i < 16; i++) m_w[i] = 1;
    load_a(0);
    reset_start("abort");
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_mid_done", int'(done_a), 0);
    chk("abort_mid_out0", int'(out_a[0 +: DW]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (done_a) break;
    end
    chk("abort_done_edge", n, 40);
    check_outs_a("abort");

    // Inputs changed once done: results must stay frozen.
    for (int oy = 0; oy < 2; oy++)
      for (int ox = 0; ox < 2; ox++)
        exp_q.push_back(ref_px(2, 4, 4, 2, 2, 0, oy, ox, 0));
    @(negedge clk);
    in_a = ~in_a;
    b_a  = 7;
    w_a  = '0;
    repeat (30) @(posedge clk);
    #1;
    chk("hold_done", int'(done_a), 1);
    check_outs_a("hold");

    // Padded 3x3, stride 1, single channel, all-ones data and weights.
    for (int i = 0; i < 16; i++) m_in[i] = 1;
    for (int i = 0; i < 16; i++) m_w[i] = 1;
    for (int i = 0; i < 16; i++) in_b[i*DW +: DW] = m_in[i];
    for (int i = 0; i < 9; i++)  w_b[i*DW +: DW]  = m_w[i];
    b_b = '0;
    for (int oy = 0; oy < 4; oy++)
      for (int ox = 0; ox < 4; ox++)
        exp_q.push_back(ref_px(1, 4, 4, 3, 1, 1, oy, ox, 0));
    reset_start("pad");
    chk("pad_rst_done_b", int'(done_b), 0);
    n = 0;
    while (n < 400) begin
      @(posedge clk); #1;
      n++;
      if (done_b) break;
    end
    chk("pad_done_edge", n, 176);
    for (int i = 0; i < 16; i++) chk($sformatf("pad_out%0d", i), int'(out_b[i*DW +: DW]), exp_q.pop_front());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
